weight_fifo: RTL and testbench

WEIGHT_FIFO -- requirements
Module: weight_fifo

---
 rtl/Weight_types.sv | 29 ++
 rtl/weight_fifo_if.sv | 52 +++++
 rtl/weight_fifo_ram.sv | 48 ++++
 rtl/weight_fifo.sv | 167 ++++++++++++++++
 tb/tb_weight_fifo.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/Weight_types.sv
// -----------------------------------------------------------------------------
// Weight_types
// Shared definitions for the weight path. The systolic array, the control unit
// and the weight FIFO all use these.
//   ROWS    : systolic array dimension (rows per tile, weights per row)
//   DATA_W  : bits per weight
//   DEPTH   : rows of FIFO storage (two complete tiles)
//   ROW_W   : bits in one packed weight row
//   w_row_t : packed weight row; weight k lives in bits [k*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
package Weight_types;

    localparam int ROWS   = 32;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;
    localparam int ROW_W  = ROWS * DATA_W;

    typedef logic [ROW_W-1:0] w_row_t;

    // Builds a row with every weight set to the same value.
    function automatic w_row_t fill_row(input logic [DATA_W-1:0] value);
        w_row_t row;
        for (int k = 0; k < ROWS; k++) begin
            row[k*DATA_W +: DATA_W] = value;
        end
        return row;
    endfunction

endpackage

// File: rtl/weight_fifo_if.sv
// -----------------------------------------------------------------------------
// weight_fifo_if
// Bundles the upstream write handshake, the control-unit pop request and the
// FIFO status/read outputs.
//   master : upstream writer + control unit (drives wr_*, load_weights_i)
//   slave  : the weight FIFO (drives wr_ready_o, rd_*, tile_rdy_o, count_o)
// Signal names keep the _i/_o suffixes as seen from the FIFO.
// -----------------------------------------------------------------------------
interface weight_fifo_if #(
    parameter int ROWS   = Weight_types::ROWS,
    parameter int DATA_W = Weight_types::DATA_W,
    parameter int DEPTH  = Weight_types::DEPTH
);

    localparam int ROW_W = ROWS * DATA_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              wr_valid_i;
    logic [ROW_W-1:0]  wr_data_i;
    logic              wr_ready_o;
    logic              load_weights_i;
    logic              rd_valid_o;
    logic [ROW_W-1:0]  rd_data_o;
    logic              rd_last_o;
    logic              tile_rdy_o;
    logic [CNT_W-1:0]  count_o;

    modport master (
        output wr_valid_i,
        output wr_data_i,
        output load_weights_i,
        input  wr_ready_o,
        input  rd_valid_o,
        input  rd_data_o,
        input  rd_last_o,
        input  tile_rdy_o,
        input  count_o
    );

    modport slave (
        input  wr_valid_i,
        input  wr_data_i,
        input  load_weights_i,
        output wr_ready_o,
        output rd_valid_o,
        output rd_data_o,
        output rd_last_o,
        output tile_rdy_o,
        output count_o
    );

endinterface

// File: rtl/weight_fifo_ram.sv
// -----------------------------------------------------------------------------
// weight_fifo_ram
// Simple dual-port row storage: one synchronous write port and one read port
// with a registered output, written so it maps onto block RAM. Neither the
// array nor the read register is reset.
// Ports:
//   clk_i      : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : row to store
//   rd_en_i    : read strobe; rd_data_o updates on the next edge
//   rd_addr_i  : read address
//   rd_data_o  : registered read data (holds when rd_en_i is low)
// -----------------------------------------------------------------------------
module weight_fifo_ram #(
    parameter int WIDTH = Weight_types::ROW_W,
    parameter int DEPTH = Weight_types::DEPTH
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port. The controller never reads and writes the same
    // address in one cycle, so read-during-write behaviour does not matter.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/weight_fifo.sv
// -----------------------------------------------------------------------------
// weight_fifo
// Row FIFO between the weight loader and the systolic array. It stores up to
// DEPTH rows (two tiles) and tracks tile boundaries so the control unit knows
// when a whole tile is resident. Each accepted pop returns its row one cycle
// later.
// Ports:
//   clk_i : clock; all state updates on the rising edge
//   rst_i : synchronous active-high reset
//   bus   : weight_fifo_if.slave
//           wr_valid_i/wr_data_i/wr_ready_o : row write handshake
//           load_weights_i                  : pop request, one row per cycle
//           rd_valid_o/rd_data_o/rd_last_o  : popped row, 1-cycle latency
//           tile_rdy_o                      : at least one full tile stored
//           count_o                         : rows currently stored
// -----------------------------------------------------------------------------
module weight_fifo #(
    parameter int ROWS   = Weight_types::ROWS,
    parameter int DATA_W = Weight_types::DATA_W,
    parameter int DEPTH  = Weight_types::DEPTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    weight_fifo_if.slave  bus
);

    import Weight_types::*;

    localparam int ROW_W = ROWS * DATA_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RC_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int TILES = DEPTH / ROWS;
    localparam int TL_W  = $clog2(TILES) + 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [RC_W-1:0]  ROW_LAST = RC_W'(ROWS - 1);
    localparam logic [RC_W-1:0]  ROW_ONE  = RC_W'(1);
    localparam logic [RC_W-1:0]  ROW_ZERO = {RC_W{1'b0}};
    localparam logic [TL_W-1:0]  TL_ONE   = TL_W'(1);
    localparam logic [TL_W-1:0]  TL_ZERO  = {TL_W{1'b0}};

    // State registers and their next values.
    logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [RC_W-1:0]  wr_row_q,    wr_row_d;
    logic [RC_W-1:0]  rd_row_q,    rd_row_d;
    logic [TL_W-1:0]  tiles_q,     tiles_d;
    logic             rd_valid_q,  rd_valid_d;
    logic             rd_last_q,   rd_last_d;
    logic             tile_rdy_q,  tile_rdy_d;

    // Per-cycle strobes.
    logic             wr_ready_s;
    logic             push_s;
    logic             pop_s;
    logic             ram_we_s;
    logic             tile_in_s;
    logic             tile_out_s;
    logic [ROW_W-1:0] rd_data_s;

    // Handshake decode. wr_ready looks only at the stored count so a full
    // FIFO refuses a row even when a pop frees a slot in the same cycle.
    always_comb begin
        wr_ready_s = (count_q < CNT_FULL);
        push_s     = bus.wr_valid_i && wr_ready_s;
        pop_s      = bus.load_weights_i && (count_q != CNT_ZERO);
        // Keep the reset cycle from touching storage.
        ram_we_s   = push_s && !rst_i;
        tile_in_s  = push_s && (wr_row_q == ROW_LAST);
        tile_out_s = pop_s && (rd_row_q == ROW_LAST);
    end

    // Pointer and row-counter next state; all of them wrap explicitly.
    always_comb begin
        if (push_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? PTR_ZERO : (wr_ptr_q + PTR_ONE);
            wr_row_d = (wr_row_q == ROW_LAST) ? ROW_ZERO : (wr_row_q + ROW_ONE);
        end else begin
            wr_ptr_d = wr_ptr_q;
            wr_row_d = wr_row_q;
        end

        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? PTR_ZERO : (rd_ptr_q + PTR_ONE);
            rd_row_d = (rd_row_q == ROW_LAST) ? ROW_ZERO : (rd_row_q + ROW_ONE);
        end else begin
            rd_ptr_d = rd_ptr_q;
            rd_row_d = rd_row_q;
        end
    end

    // Occupancy and tile counters; simultaneous in/out leaves them unchanged.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        case ({tile_in_s, tile_out_s})
            2'b10:   tiles_d = tiles_q + TL_ONE;
            2'b01:   tiles_d = tiles_q - TL_ONE;
            default: tiles_d = tiles_q;
        endcase
    end

    // Registered output flags. tile_rdy is taken from tiles_d so that the
    // flop always equals (tiles_q != 0) on the same cycle.
    always_comb begin
        rd_valid_d = pop_s;
        rd_last_d  = tile_out_s;
        tile_rdy_d = (tiles_d != TL_ZERO);
    end

    // State register with synchronous reset; row storage is not reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            count_q    <= CNT_ZERO;
            wr_row_q   <= ROW_ZERO;
            rd_row_q   <= ROW_ZERO;
            tiles_q    <= TL_ZERO;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            tile_rdy_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wr_row_q   <= wr_row_d;
            rd_row_q   <= rd_row_d;
            tiles_q    <= tiles_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            tile_rdy_q <= tile_rdy_d;
        end
    end

    weight_fifo_ram #(
        .WIDTH (ROW_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (ram_we_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (bus.wr_data_i),
        .rd_en_i   (pop_s),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data_s)
    );

    assign bus.wr_ready_o = wr_ready_s;
    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_data_o  = rd_data_s;
    assign bus.rd_last_o  = rd_last_q;
    assign bus.tile_rdy_o = tile_rdy_q;
    assign bus.count_o    = count_q;

endmodule

// File: tb/tb_weight_fifo.sv
// -----------------------------------------------------------------------------
// tb_weight_fifo
// Directed bench for weight_fifo. Every accepted write pushes its row into a
// scoreboard queue; every rd_valid_o pulse pops the oldest row and compares it.
// Occupancy, tile and last-row expectations come from a small model.
// -----------------------------------------------------------------------------
module tb_weight_fifo;

    import Weight_types::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    weight_fifo_if #(.ROWS(ROWS), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    weight_fifo #(
        .ROWS   (ROWS),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    w_row_t sb_q[$];
    int     m_count;
    int     m_wrow;
    int     m_rrow;
    int     m_tiles;

    task automatic check(input string tag, input w_row_t obs, input w_row_t exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic w_row_t rand_row();
        w_row_t r;
        for (int i = 0; i < ROW_W / 32; i++) begin
            r[i*32 +: 32] = $urandom();
        end
        return r;
    endfunction

    // One clock cycle: drive inputs, advance the model, then check outputs.
    task automatic step(input logic wv, input w_row_t wd, input logic ld);
        bit     acc;
        bit     do_pop;
        bit     exp_last;
        w_row_t exp_row;
        bus.wr_valid_i     = wv;
        bus.wr_data_i      = wd;
        bus.load_weights_i = ld;
        check("wr_ready", w_row_t'(bus.wr_ready_o), w_row_t'(m_count < DEPTH));
        acc      = wv && (m_count < DEPTH);
        do_pop   = ld && (m_count != 0);
        exp_last = 1'b0;
        if (do_pop) begin
            exp_last = (m_rrow == ROWS - 1);
            m_rrow   = (m_rrow + 1) % ROWS;
            if (exp_last) m_tiles--;
            m_count--;
        end
        if (acc) begin
            sb_q.push_back(wd);
            if (m_wrow == ROWS - 1) m_tiles++;
            m_wrow = (m_wrow + 1) % ROWS;
            m_count++;
        end
        @(posedge clk);
        #1;
        check("rd_valid", w_row_t'(bus.rd_valid_o), w_row_t'(do_pop));
        if (bus.rd_valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("rd_unexpected", w_row_t'(1'b1), w_row_t'(1'b0));
            end else begin
                exp_row = sb_q.pop_front();
                check("rd_data", bus.rd_data_o, exp_row);
                check("rd_last", w_row_t'(bus.rd_last_o), w_row_t'(exp_last));
            end
        end
        check("count", w_row_t'(bus.count_o), w_row_t'(m_count));
        check("tile_rdy", w_row_t'(bus.tile_rdy_o), w_row_t'(m_tiles != 0));
    endtask

    // Reset for one cycle with the given write/pop activity, then check.
    task automatic do_reset(input logic wv, input logic ld);
        rst                = 1'b1;
        bus.wr_valid_i     = wv;
        bus.wr_data_i      = fill_row(8'hEE);
        bus.load_weights_i = ld;
        @(posedge clk);
        #1;
        rst                = 1'b0;
        bus.wr_valid_i     = 1'b0;
        bus.load_weights_i = 1'b0;
        sb_q.delete();
        m_count = 0;
        m_wrow  = 0;
        m_rrow  = 0;
        m_tiles = 0;
        check("rst_count", w_row_t'(bus.count_o), w_row_t'(0));
        check("rst_tile_rdy", w_row_t'(bus.tile_rdy_o), w_row_t'(1'b0));
        check("rst_rd_valid", w_row_t'(bus.rd_valid_o), w_row_t'(1'b0));
        check("rst_rd_last", w_row_t'(bus.rd_last_o), w_row_t'(1'b0));
        check("rst_wr_ready", w_row_t'(bus.wr_ready_o), w_row_t'(1'b1));
    endtask

    initial begin
        rst                = 1'b1;
        bus.wr_valid_i     = 1'b0;
        bus.wr_data_i      = '0;
        bus.load_weights_i = 1'b0;
        @(posedge clk);
        #1;
        do_reset(1'b0, 1'b0);

        // One full tile of rows 0..31; tile_rdy must rise after the 32nd write.
        for (int k = 0; k < ROWS; k++) begin
            step(1'b1, fill_row(8'(k)), 1'b0);
        end
        check("tile_full_rdy", w_row_t'(bus.tile_rdy_o), w_row_t'(1'b1));
        check("tile_full_count", w_row_t'(bus.count_o), w_row_t'(ROWS));

        // Drain the tile; rd_last only on row 31.
        for (int k = 0; k < ROWS; k++) begin
            step(1'b0, '0, 1'b1);
        end
        check("drain_tile_rdy", w_row_t'(bus.tile_rdy_o), w_row_t'(1'b0));
        check("drain_count", w_row_t'(bus.count_o), w_row_t'(0));

        // Pops on an empty FIFO are ignored.
        for (int k = 0; k < 5; k++) begin
            step(1'b0, '0, 1'b1);
        end

        // Fill to DEPTH with valid held; the 65th row is refused until a pop.
        for (int k = 0; k <= DEPTH; k++) begin
            step(1'b1, fill_row(8'(64 + k)), 1'b0);
        end
        check("full_wr_ready", w_row_t'(bus.wr_ready_o), w_row_t'(1'b0));
        check("full_count", w_row_t'(bus.count_o), w_row_t'(DEPTH));
        step(1'b1, fill_row(8'(64 + DEPTH)), 1'b1);
        step(1'b1, fill_row(8'(64 + DEPTH)), 1'b0);
        check("refill_count", w_row_t'(bus.count_o), w_row_t'(DEPTH));
        for (int k = 0; k < DEPTH; k++) begin
            step(1'b0, '0, 1'b1);
        end

        // Steady state at count 10 with a write and a pop every cycle.
        for (int k = 0; k < 10; k++) begin
            step(1'b1, rand_row(), 1'b0);
        end
        for (int k = 0; k < 100; k++) begin
            step(1'b1, rand_row(), 1'b1);
        end
        check("steady_count", w_row_t'(bus.count_o), w_row_t'(10));
        for (int k = 0; k < 10; k++) begin
            step(1'b0, '0, 1'b1);
        end

        // Reset mid-operation with a write and pop in the reset cycle.
        for (int k = 0; k < 40; k++) begin
            step(1'b1, rand_row(), 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, '0, 1'b1);
        end
        do_reset(1'b1, 1'b1);

        // Old contents are gone: the next write is the next row read.
        step(1'b1, fill_row(8'h5A), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
